regfile_write_arbiter: RTL

// - Shares the single register-file write port (regwrite/write_reg/write_data) between two writeback requesters.

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clears all registers after reset, then shares the
// single write port between ALU writeback (req0) and load writeback (req1).
// Latency 1 cycle from accept to rf_* write; backpressure only through req*_ready.
// Optional: define REGFILE_WRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration
// under contention; when it is undefined, req0 has fixed priority.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_grant_id,
  output logic              init_busy
);

  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;

  logic              grant_vld;
  logic              grant_sel;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Pick at most one requester per cycle; nobody is served during the clear sequence.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (state == ST_RUN) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
`ifdef REGFILE_WRITE_ARB_ROUND_ROBIN_EN
        // Favour whoever did not win the last accepted transfer.
        grant_sel = ~last_grant;
`else
        // Fixed priority: ALU writeback always wins, loads may starve.
        grant_sel = 1'b0;
`endif
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_sel = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_sel;
  assign req1_ready = grant_vld &  grant_sel;
  assign init_busy  = (state == ST_INIT);

  // Route the winning requester's address and data toward the write port.
  always_comb begin
    sel_reg  = req0_reg;
    sel_data = req0_data;
    if (grant_sel) begin
      sel_reg  = req1_reg;
      sel_data = req1_data;
    end
  end

  // Clear-sequence counter and INIT -> RUN transition; reset restarts the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_LAST) begin
        state <= ST_RUN;
        cnt   <= '0;
      end
    end
  end

  // Registered write port: clear writes in INIT, accepted requests in RUN.
  // Writes to x0 are accepted but suppressed, and the address/data hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_regwrite   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_grant_id   <= 1'b0;
    end else if (state == ST_INIT) begin
      rf_regwrite   <= 1'b1;
      rf_write_reg  <= ADDR_W'(cnt);
      rf_write_data <= '0;
      rf_grant_id   <= 1'b0;
    end else if (grant_vld) begin
      rf_grant_id <= grant_sel;
      if (sel_reg != '0) begin
        rf_regwrite   <= 1'b1;
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end else begin
        rf_regwrite <= 1'b0;
      end
    end else begin
      rf_regwrite <= 1'b0;
    end
  end

  // Remember the winner of the most recent accepted transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_vld) begin
      last_grant <= grant_sel;
    end
  end

endmodule
